// File: rtl/register_bank.sv
// Register bank loaded byte-by-byte from a PC link with a staged commit, plus a fabric-side load.
// Optional staging timeout is enabled by defining REGISTER_BANK_TIMEOUT_EN.
module register_bank #(
    parameter int                      NUM_REGS       = 4,
    parameter int                      DATA_BYTES     = 4,
    parameter logic [8*DATA_BYTES-1:0] RESET_VALUE    = '0,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write,
    input  logic [$clog2(NUM_REGS)-1:0]         write_sel,
    input  logic [$clog2(DATA_BYTES)-1:0]       write_byte,
    input  logic [7:0]                          write_data,
    input  logic                                write_done,
    input  logic [NUM_REGS-1:0]                 read_ack,
    input  logic [NUM_REGS-1:0]                 hw_write,
    input  logic [8*DATA_BYTES*NUM_REGS-1:0]    hw_data,
    input  logic                                err_clr,
    output logic [8*DATA_BYTES*NUM_REGS-1:0]    data,
    output logic [NUM_REGS-1:0]                 changed,
    output logic                                busy,
    output logic                                err,
    output logic                                dbg_state
);

    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int BYTE_W = $clog2(DATA_BYTES);
    localparam int W      = 8 * DATA_BYTES;

    // Handshake: write is sampled as a one-cycle byte strobe on each rising edge;
    // write_done commits whatever is staged (including a same-cycle byte). No back-pressure.
    typedef enum logic {
        IDLE  = 1'b0,
        STAGE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [W-1:0]          stage_q, stage_d;
    logic [DATA_BYTES-1:0] mask_q, mask_d;
    logic [W-1:0]          data_q [NUM_REGS];
    logic [W-1:0]          data_d [NUM_REGS];
    logic [NUM_REGS-1:0]   changed_q, changed_d;
    logic                  err_q, err_d;

    logic                  commit;
    logic                  discard;
    logic                  take_byte;
    logic                  timeout_hit;
    logic [W-1:0]          stage_n;
    logic [DATA_BYTES-1:0] mask_n;

`ifdef REGISTER_BANK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stage_quiet;

    always_comb begin
        stage_quiet = (state_q == STAGE) && !write && !write_done;
        timeout_hit = stage_quiet && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d       = '0;
        if (stage_quiet && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_d     = err_q & ~err_clr;
        changed_d = changed_q & ~read_ack;
        data_d    = data_q;
        commit    = 1'b0;
        discard   = 1'b0;
        take_byte = 1'b0;

        case (state_q)
            IDLE: begin
                if (write) begin
                    take_byte = 1'b1;
                    sel_d     = write_sel;
                    commit    = write_done;
                    state_d   = write_done ? IDLE : STAGE;
                end
            end
            STAGE: begin
                if (write && (write_sel != sel_q)) begin
                    discard = 1'b1;
                end else if (write || write_done) begin
                    take_byte = write;
                    commit    = write_done;
                    if (write_done) begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    discard = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh transaction starts from an empty mask regardless of leftover staging bytes.
        stage_n = stage_q;
        mask_n  = (state_q == IDLE) ? '0 : mask_q;
        if (take_byte) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (write_byte == BYTE_W'(b)) begin
                    stage_n[b*8 +: 8] = write_data;
                    mask_n[b]         = 1'b1;
                end
            end
        end
        stage_d = stage_n;
        mask_d  = mask_n;

        if (commit || discard) begin
            mask_d = '0;
        end
        if (discard) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end

        // PC commit beats a fabric load on the same register.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (sel_d == SEL_W'(i))) begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (mask_n[b]) begin
                        data_d[i][b*8 +: 8] = stage_n[b*8 +: 8];
                    end
                end
                changed_d[i] = 1'b1;
            end else if (hw_write[i]) begin
                data_d[i] = hw_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            stage_q   <= '0;
            mask_q    <= '0;
            changed_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            stage_q   <= stage_d;
            mask_q    <= mask_d;
            changed_q <= changed_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            data[i*W +: W] = data_q[i];
        end
    end

    assign changed   = changed_q;
    assign busy      = (state_q == STAGE);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: staged PC writes, errors, priorities, async reset, staging timeout.
module tb_register_bank;

    logic         clk;
    logic         reset;
    logic         write;
    logic [1:0]   write_sel;
    logic [1:0]   write_byte;
    logic [7:0]   write_data;
    logic         write_done;
    logic [3:0]   read_ack;
    logic [3:0]   hw_write;
    logic [127:0] hw_data;
    logic         err_clr;
    logic [127:0] data;
    logic [3:0]   changed;
    logic         busy;
    logic         err;
    logic         dbg_state;

    int total = 0;
    int bad   = 0;

    register_bank #(
        .NUM_REGS      (4),
        .DATA_BYTES    (4),
        .RESET_VALUE   (32'h0),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .write_sel (write_sel),
        .write_byte(write_byte),
        .write_data(write_data),
        .write_done(write_done),
        .read_ack  (read_ack),
        .hw_write  (hw_write),
        .hw_data   (hw_data),
        .err_clr   (err_clr),
        .data      (data),
        .changed   (changed),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write      = 1'b0;
        write_done = 1'b0;
        read_ack   = '0;
        hw_write   = '0;
        err_clr    = 1'b0;
    endtask

    task automatic pc_byte(input logic [1:0] sel, input logic [1:0] b, input logic [7:0] v, input logic done);
        write      = 1'b1;
        write_sel  = sel;
        write_byte = b;
        write_data = v;
        write_done = done;
        step();
        idle_inputs();
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return data[i*32 +: 32];
    endfunction

    initial begin
        reset      = 1'b1;
        write_sel  = '0;
        write_byte = '0;
        write_data = '0;
        hw_data    = '0;
        idle_inputs();
        step();
        step();
        check("reset_data", data, 128'h0);
        check("reset_changed", changed, 4'b0000);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err, 1'b0);
        reset = 1'b0;
        step();

        // Full four-byte transaction to register 1
        pc_byte(2'd1, 2'd0, 8'h11, 1'b0);
        check("stage_busy", busy, 1'b1);
        check("stage_dbg", dbg_state, 1'b1);
        pc_byte(2'd1, 2'd1, 8'h22, 1'b0);
        pc_byte(2'd1, 2'd2, 8'h33, 1'b0);
        pc_byte(2'd1, 2'd3, 8'h44, 1'b0);
        check("no_early_commit", reg_of(1), 32'h0);
        write_done = 1'b1;
        step();
        idle_inputs();
        check("full_commit", data, {32'h0, 32'h0, 32'h44332211, 32'h0});
        check("full_changed", changed, 4'b0010);
        check("full_busy", busy, 1'b0);
        read_ack = 4'b0010;
        step();
        idle_inputs();
        check("ack_clear", changed, 4'b0000);

        // Single-byte transaction with same-cycle write_done
        pc_byte(2'd2, 2'd1, 8'hAB, 1'b1);
        check("single_byte", reg_of(2), 32'h0000AB00);
        check("single_changed", changed, 4'b0100);
        check("single_busy", busy, 1'b0);

        // Repeated byte index overwrites the staged value
        pc_byte(2'd3, 2'd0, 8'h55, 1'b0);
        pc_byte(2'd3, 2'd0, 8'h66, 1'b0);
        pc_byte(2'd3, 2'd2, 8'h77, 1'b1);
        check("overwrite", reg_of(3), 32'h00770066);
        check("overwrite_changed", changed, 4'b1100);
        read_ack = 4'hF;
        step();
        idle_inputs();

        // Select switch mid-transaction is a protocol error
        pc_byte(2'd0, 2'd0, 8'h99, 1'b0);
        pc_byte(2'd3, 2'd1, 8'h12, 1'b0);
        check("sel_err", err, 1'b1);
        check("sel_err_data0", reg_of(0), 32'h0);
        check("sel_err_data3", reg_of(3), 32'h00770066);
        check("sel_err_changed", changed, 4'b0000);
        check("sel_err_busy", busy, 1'b0);
        err_clr = 1'b1;
        step();
        idle_inputs();
        check("err_clr", err, 1'b0);

        // err_clr loses against a same-cycle error
        pc_byte(2'd0, 2'd0, 8'h01, 1'b0);
        err_clr = 1'b1;
        pc_byte(2'd1, 2'd0, 8'h02, 1'b0);
        check("err_set_wins", err, 1'b1);
        err_clr = 1'b1;
        step();
        idle_inputs();

        // write_done alone in IDLE does nothing
        write_done = 1'b1;
        step();
        idle_inputs();
        check("lone_done_changed", changed, 4'b0000);
        check("lone_done_busy", busy, 1'b0);

        // Fabric load does not flag changed
        hw_write          = 4'b0001;
        hw_data[31:0]     = 32'hDEADBEEF;
        step();
        idle_inputs();
        check("hw_load", reg_of(0), 32'hDEADBEEF);
        check("hw_changed", changed, 4'b0000);

        // Commit beats hw_write and read_ack on the same register
        pc_byte(2'd1, 2'd2, 8'hCC, 1'b0);
        write_done     = 1'b1;
        hw_write       = 4'b0011;
        read_ack       = 4'b0010;
        hw_data[31:0]  = 32'h01020304;
        hw_data[63:32] = 32'hFFFFFFFF;
        step();
        idle_inputs();
        check("prio_data1", reg_of(1), 32'h44CC2211);
        check("prio_data0", reg_of(0), 32'h01020304);
        check("prio_changed", changed, 4'b0010);
        read_ack = 4'hF;
        step();
        idle_inputs();

        // Asynchronous reset mid-STAGE
        pc_byte(2'd2, 2'd0, 8'h5A, 1'b0);
        check("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_data", data, 128'h0);
        check("async_busy", busy, 1'b0);
        check("async_err", err, 1'b0);
        #3;
        reset = 1'b0;
        step();
        write_done = 1'b1;
        step();
        idle_inputs();
        check("post_reset_data", data, 128'h0);
        check("post_reset_changed", changed, 4'b0000);

        // Staging timeout
        pc_byte(2'd0, 2'd3, 8'h7E, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
        end
        check("timeout_7_busy", busy, 1'b1);
        step();
`ifdef REGISTER_BANK_TIMEOUT_EN
        check("timeout_err", err, 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_data", reg_of(0), 32'h0);
        write_done = 1'b1;
        step();
        idle_inputs();
        check("timeout_no_commit", reg_of(0), 32'h0);
`else
        check("no_timeout_busy", busy, 1'b1);
        check("no_timeout_err", err, 1'b0);
        write_done = 1'b1;
        step();
        idle_inputs();
        check("late_commit", reg_of(0), 32'h7E000000);
        check("late_changed", changed, 4'b0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
